// File: rtl/swin_seq_ctrl_if.sv
// Host/DMA-side and datapath-side buses of the sliding-window sequencer.
// master = bench/host view, slave = sequencer view.
interface swin_seq_ctrl_if #(
   parameter int CONF_DATA_WIDTH = 19,
   parameter int CONF_ADDR_WIDTH = 4
);
   logic [CONF_DATA_WIDTH-1:0] conf_in_data;
   logic                       conf_in_vld;
   logic                       conf_in_rdy;
   logic [127:0]               pix_in_data;
   logic                       pix_in_vld;
   logic                       pix_in_rdy;
   logic [CONF_ADDR_WIDTH-1:0] conf_bram_wr_addr;
   logic [CONF_DATA_WIDTH-1:0] conf_bram_wr_data_in;
   logic                       conf_bram_wr_data_en;
   logic [127:0]               pix_data_in;
   logic                       data_in_vld;

   modport master (
      output conf_in_data, conf_in_vld,
      output pix_in_data, pix_in_vld,
      input  conf_in_rdy, pix_in_rdy,
      input  conf_bram_wr_addr, conf_bram_wr_data_in,
      input  conf_bram_wr_data_en,
      input  pix_data_in, data_in_vld
   );

   modport slave (
      input  conf_in_data, conf_in_vld,
      input  pix_in_data, pix_in_vld,
      output conf_in_rdy, pix_in_rdy,
      output conf_bram_wr_addr, conf_bram_wr_data_in,
      output conf_bram_wr_data_en,
      output pix_data_in, data_in_vld
   );
endinterface

// File: rtl/swin_seq_ctrl.sv
// Config-load and frame-streaming sequencer for the sliding-window datapath.
// Define SWIN_SEQ_ROWGAP_EN to insert one stall cycle between rows.
module swin_seq_ctrl #(
   parameter int CONF_DATA_WIDTH = 19,
   parameter int CONF_ADDR_WIDTH = 4,
   parameter int CONF_DEPTH      = 16,
   parameter int COL_W           = 8,
   parameter int ROW_W           = 10
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             skip_conf,
   input  logic [COL_W-1:0] row_beats,
   input  logic [ROW_W-1:0] frame_rows,
   swin_seq_ctrl_if.slave   bus,
   output logic             busy,
   output logic             frame_done,
   output logic             cfg_err
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_RUN,
`ifdef SWIN_SEQ_ROWGAP_EN
      S_GAP,
`endif
      S_DONE
   } state_e;

   localparam logic [CONF_ADDR_WIDTH-1:0] LAST_CONF =
      CONF_ADDR_WIDTH'(CONF_DEPTH - 1);

   state_e                     state_q, state_d;
   logic [CONF_ADDR_WIDTH-1:0] conf_cnt_q, conf_cnt_d;
   logic [COL_W-1:0]           col_cnt_q, col_cnt_d;
   logic [ROW_W-1:0]           row_cnt_q, row_cnt_d;
   logic [COL_W-1:0]           rb_q, rb_d;
   logic [ROW_W-1:0]           fr_q, fr_d;
   logic                       cfg_err_q, cfg_err_d;
   logic [CONF_ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
   logic [CONF_DATA_WIDTH-1:0] wr_data_q, wr_data_d;
   logic                       wr_en_q, wr_en_d;
   logic [127:0]               pix_q, pix_d;
   logic                       vld_q, vld_d;

   logic conf_rdy, pix_rdy;
   logic conf_hs, pix_hs;
   logic bad_cfg;
   logic row_end, frame_end;

   assign conf_rdy  = (state_q == S_LOAD);
   assign pix_rdy   = (state_q == S_RUN);
   assign conf_hs   = conf_rdy & bus.conf_in_vld;
   assign pix_hs    = pix_rdy & bus.pix_in_vld;
   assign bad_cfg   = (row_beats == '0) || (frame_rows == '0);
   assign row_end   = (col_cnt_q == rb_q - COL_W'(1));
   assign frame_end = (row_cnt_q == fr_q - ROW_W'(1));

   always_comb begin
      state_d    = state_q;
      conf_cnt_d = conf_cnt_q;
      col_cnt_d  = col_cnt_q;
      row_cnt_d  = row_cnt_q;
      rb_d       = rb_q;
      fr_d       = fr_q;
      cfg_err_d  = 1'b0;

      // Strobes follow the handshake by one cycle; buses keep last value.
      wr_en_d   = conf_hs;
      wr_addr_d = conf_hs ? conf_cnt_q : wr_addr_q;
      wr_data_d = conf_hs ? bus.conf_in_data : wr_data_q;
      vld_d     = pix_hs;
      pix_d     = pix_hs ? bus.pix_in_data : pix_q;

      unique case (state_q)
         S_IDLE: begin
            unique case (1'b1)
               !start: ;
               start && bad_cfg: cfg_err_d = 1'b1;
               start && !bad_cfg: begin
                  rb_d    = row_beats;
                  fr_d    = frame_rows;
                  state_d = skip_conf ? S_RUN : S_LOAD;
               end
            endcase
         end
         S_LOAD: begin
            if (conf_hs) begin
               if (conf_cnt_q == LAST_CONF) begin
                  conf_cnt_d = '0;
                  state_d    = S_RUN;
               end else begin
                  conf_cnt_d = conf_cnt_q + CONF_ADDR_WIDTH'(1);
               end
            end
         end
         S_RUN: begin
            if (pix_hs) begin
               if (row_end) begin
                  col_cnt_d = '0;
                  if (frame_end) begin
                     row_cnt_d = '0;
                     state_d   = S_DONE;
                  end else begin
                     row_cnt_d = row_cnt_q + ROW_W'(1);
`ifdef SWIN_SEQ_ROWGAP_EN
                     state_d   = S_GAP;
`endif
                  end
               end else begin
                  col_cnt_d = col_cnt_q + COL_W'(1);
               end
            end
         end
`ifdef SWIN_SEQ_ROWGAP_EN
         S_GAP: state_d = S_RUN;
`endif
         S_DONE: begin
            state_d    = S_IDLE;
            conf_cnt_d = '0;
            col_cnt_d  = '0;
            row_cnt_d  = '0;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         conf_cnt_q <= '0;
         col_cnt_q  <= '0;
         row_cnt_q  <= '0;
         rb_q       <= '0;
         fr_q       <= '0;
         cfg_err_q  <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         wr_en_q    <= 1'b0;
         pix_q      <= '0;
         vld_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         conf_cnt_q <= conf_cnt_d;
         col_cnt_q  <= col_cnt_d;
         row_cnt_q  <= row_cnt_d;
         rb_q       <= rb_d;
         fr_q       <= fr_d;
         cfg_err_q  <= cfg_err_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         wr_en_q    <= wr_en_d;
         pix_q      <= pix_d;
         vld_q      <= vld_d;
      end
   end

   assign bus.conf_in_rdy          = conf_rdy;
   assign bus.pix_in_rdy           = pix_rdy;
   assign bus.conf_bram_wr_addr    = wr_addr_q;
   assign bus.conf_bram_wr_data_in = wr_data_q;
   assign bus.conf_bram_wr_data_en = wr_en_q;
   assign bus.pix_data_in          = pix_q;
   assign bus.data_in_vld          = vld_q;

   assign busy       = (state_q != S_IDLE);
   assign frame_done = (state_q == S_DONE);
   assign cfg_err    = cfg_err_q;

endmodule

// File: tb/tb_swin_seq_ctrl.sv
// Bench for swin_seq_ctrl: frame table plus reset/reload sequence,
// with queue scoreboards for config writes and pixel beats.
module tb_swin_seq_ctrl;
   localparam int CDW  = 19;
   localparam int CAW  = 4;
   localparam int COLW = 8;
   localparam int ROWW = 10;
`ifdef SWIN_SEQ_ROWGAP_EN
   localparam bit GAP_EN = 1'b1;
`else
   localparam bit GAP_EN = 1'b0;
`endif

   typedef struct {
      bit skip;
      int rb;
      int fr;
      bit tog;
      bit inj;
      bit exp_err;
      int exp_beats;
      int exp_gaps;
   } vec_t;

   logic            clk = 1'b0;
   logic            rst_n = 1'b1;
   logic            start = 1'b0;
   logic            skip_conf = 1'b0;
   logic [COLW-1:0] row_beats = '0;
   logic [ROWW-1:0] frame_rows = '0;
   logic            busy, frame_done, cfg_err;

   int n_vec = 0;
   int n_err = 0;
   logic [127:0]       sb_pix[$];
   logic [CAW+CDW-1:0] sb_conf[$];

   swin_seq_ctrl_if #(.CONF_DATA_WIDTH(CDW), .CONF_ADDR_WIDTH(CAW)) bus();

   swin_seq_ctrl #(
      .CONF_DATA_WIDTH(CDW), .CONF_ADDR_WIDTH(CAW), .CONF_DEPTH(16),
      .COL_W(COLW), .ROW_W(ROWW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .skip_conf(skip_conf),
      .row_beats(row_beats), .frame_rows(frame_rows), .bus(bus),
      .busy(busy), .frame_done(frame_done), .cfg_err(cfg_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [127:0] got,
                      input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.data_in_vld) begin
            if (sb_pix.size() == 0) chk("pix_unexpected", bus.data_in_vld, 1'b0);
            else chk("pix_data", bus.pix_data_in, sb_pix.pop_front());
         end
         if (bus.conf_bram_wr_data_en) begin
            if (sb_conf.size() == 0)
               chk("conf_unexpected", bus.conf_bram_wr_data_en, 1'b0);
            else
               chk("conf_write", {bus.conf_bram_wr_addr, bus.conf_bram_wr_data_in},
                   sb_conf.pop_front());
         end
      end
   end

   function automatic vec_t mk(bit skip, int rb, int fr, bit tog, bit inj);
      vec_t v;
      v.skip      = skip;
      v.rb        = rb;
      v.fr        = fr;
      v.tog       = tog;
      v.inj       = inj;
      v.exp_err   = (rb == 0) || (fr == 0);
      v.exp_beats = rb * fr;
      v.exp_gaps  = (GAP_EN && fr > 0) ? fr - 1 : 0;
      return v;
   endfunction

   task automatic check_zero_outputs(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, frame_done, 0);
      chk({tag, "_err"}, cfg_err, 0);
      chk({tag, "_crdy"}, bus.conf_in_rdy, 0);
      chk({tag, "_prdy"}, bus.pix_in_rdy, 0);
      chk({tag, "_wen"}, bus.conf_bram_wr_data_en, 0);
      chk({tag, "_waddr"}, bus.conf_bram_wr_addr, 0);
      chk({tag, "_wdata"}, bus.conf_bram_wr_data_in, 0);
      chk({tag, "_vld"}, bus.data_in_vld, 0);
      chk({tag, "_pix"}, bus.pix_data_in, 0);
   endtask

   task automatic load_conf(input int n, input int base);
      int got = 0;
      int cyc = 0;
      while (got < n && cyc < 200) begin
         bus.conf_in_vld  = 1'b1;
         bus.conf_in_data = CDW'(base + got);
         if (bus.conf_in_rdy) begin
            sb_conf.push_back({CAW'(got), CDW'(base + got)});
            got++;
         end
         @(posedge clk); #1;
         cyc++;
      end
      bus.conf_in_vld = 1'b0;
      chk("conf_words", got, n);
      chk("conf_cycles", cyc, n);
   endtask

   task automatic issue_start(input vec_t v);
      start      = 1'b1;
      skip_conf  = v.skip;
      row_beats  = COLW'(v.rb);
      frame_rows = ROWW'(v.fr);
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic run_frame(input vec_t v, input int base);
      int beats = 0;
      int gaps  = 0;
      int cyc   = 0;
      issue_start(v);
      if (v.exp_err) begin
         chk("cfg_err_pulse", cfg_err, 1);
         chk("err_busy", busy, 0);
         @(posedge clk); #1;
         chk("cfg_err_clr", cfg_err, 0);
         chk("err_busy2", busy, 0);
         return;
      end
      chk("busy_rise", busy, 1);
      chk("load_entry", bus.conf_in_rdy, !v.skip);
      if (!v.skip) load_conf(16, base);
      chk("run_entry", bus.pix_in_rdy, 1);
      while (beats < v.exp_beats && cyc < 2000) begin
         bus.pix_in_vld  = v.tog ? (cyc % 2 == 0) : 1'b1;
         bus.pix_in_data = {$urandom(), $urandom(), $urandom(), $urandom()};
         if (v.inj && cyc == 2) begin
            start      = 1'b1;
            row_beats  = '0;
            frame_rows = '0;
         end
         if (!bus.pix_in_rdy) gaps++;
         else if (bus.pix_in_vld) begin
            sb_pix.push_back(bus.pix_in_data);
            beats++;
         end
         @(posedge clk); #1;
         cyc++;
         if (v.inj && cyc == 3) begin
            start = 1'b0;
            chk("start_in_run_err", cfg_err, 0);
            chk("start_in_run_busy", busy, 1);
         end
      end
      bus.pix_in_vld = 1'b0;
      chk("beats", beats, v.exp_beats);
      chk("gaps", gaps, v.exp_gaps);
      chk("frame_done", frame_done, 1);
      chk("done_busy", busy, 1);
      chk("done_prdy", bus.pix_in_rdy, 0);
      @(posedge clk); #1;
      chk("frame_done_clr", frame_done, 0);
      chk("idle", busy, 0);
      chk("pix_sb_empty", sb_pix.size(), 0);
      chk("conf_sb_empty", sb_conf.size(), 0);
   endtask

   initial begin
      vec_t tbl[8];
      vec_t v;
      tbl[0] = mk(0, 4, 3, 0, 0);
      tbl[1] = mk(1, 4, 3, 0, 0);
      tbl[2] = mk(1, 4, 3, 1, 0);
      tbl[3] = mk(1, 0, 3, 0, 0);
      tbl[4] = mk(1, 4, 0, 0, 0);
      tbl[5] = mk(1, 4, 2, 0, 1);
      tbl[6] = mk(1, 1, 1, 0, 0);
      tbl[7] = mk(0, 3, 2, 1, 0);

      bus.conf_in_data = '0;
      bus.conf_in_vld  = 1'b0;
      bus.pix_in_data  = '0;
      bus.pix_in_vld   = 1'b0;
      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_zero_outputs("rst");
      rst_n = 1'b1;
      @(posedge clk); #1;
      check_zero_outputs("post_rst");

      // Entries run back-to-back: each start lands the cycle after IDLE.
      for (int i = 0; i < 8; i++) run_frame(tbl[i], i * 32);

      // Reset in the middle of a config load, then a full reload.
      v = mk(0, 2, 2, 0, 0);
      issue_start(v);
      load_conf(8, 'h100);
      #2 rst_n = 1'b0;
      #1;
      check_zero_outputs("mid_rst");
      sb_conf.delete();
      sb_pix.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      run_frame(v, 'h200);
      run_frame(tbl[1], 'h300);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, miscompares %0d", n_err);
      $fatal(1);
   end
endmodule
